xgriscv_sc: RTL and testbench
=============================

Name: xgriscv_sc

Overview:
- Single-cycle RV32I processor core with its own instruction memory and data memory.
- Every instruction fetches, decodes, executes, accesses memory and writes back in one clock cycle.
- The only external interface is the clock, the reset and a retire-PC observation port used by the simulation benches.
- Program images are loaded into the instruction memory array by hierarchical reference before reset is released.

Parameters:
- IMEM_WORDS, 256, depth of instruction memory in 32-bit words.
- DMEM_WORDS, 256, depth of data memory in 32-bit words.
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- pcW  output  32  PC of the instruction executing/retiring in the current cycle.

Behaviour:
- Reset (rstn=0, asynchronous):
  - PC = RESET_PC; pcW = RESET_PC.
  - All 32 registers cleared to 0.
  - Data memory is not cleared.
  - Instruction memory is never modified by reset.
- Instruction memory:
  - Instance name U_imem; contains reg array RAM[0:IMEM_WORDS-1] of 32-bit words.
  - Combinational read; index = PC[log2(IMEM_WORDS)+1:2].
  - PC[1:0] ignored; out-of-range addresses wrap modulo depth.
- Data memory:
  - Instance name U_dmem; word array, byte-addressable.
  - Combinational read; synchronous write on the rising edge, gated by byte enables.
  - Out-of-range addresses wrap modulo depth.
- Register file:
  - 32x32, two combinational read ports, one write port written on the rising edge.
  - x0 always reads 0; writes to x0 are discarded.
- pcW = current PC every cycle; the next cycle's pcW is the next PC.
- Next PC, evaluated in priority order:
  - jal: PC + J-imm.
  - jalr: (rs1 + I-imm) with bit0 cleared.
  - Taken branch: PC + B-imm.
  - Otherwise: PC + 4.
- Supported instructions:
  - lui, auipc.
  - jal, jalr; both write PC+4 to rd.
  - beq, bne, blt, bge, bltu, bgeu. blt/bge compare signed; bltu/bgeu compare unsigned.
  - lb, lh, lw, lbu, lhu. lb/lh sign-extend; lbu/lhu zero-extend. Byte/half selected by address[1:0]/address[1].
  - sb, sh, sw. Little-endian byte lanes; sb writes one lane, sh two lanes, sw all four.
  - addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - add, sub, sll, slt, sltu, xor, or, and, srl, sra.
- Arithmetic:
  - All 32-bit, wrap-around on overflow, no exceptions.
  - Shift amount is the low 5 bits of the operand.
  - Immediates sign-extended per the RV32I format; U-imm = inst[31:12]<<12.
- Unsupported or illegal encodings (fence, ecall, ebreak, csr*, unknown opcodes) execute as nop: no register or memory write, PC+4.
- Misaligned loads/stores: the address is truncated to the containing word and the lanes are selected by the low bits as above; no trap. A half-word at offset 3 is unspecified and not tested.
- Misaligned jump/branch targets are not trapped; the target is used as is, and fetch ignores bits [1:0].
- nop encoding 32'h00000013 has no architectural effect beyond PC+4.
- The core runs indefinitely; there is no halt state.

Test Plan:
- Reset/fetch: RAM[0..2] = addi x5,x0,0 / addi x6,x0,0 / lui x7,0xFFFFF; release rstn -> pcW 0,4,8 on successive cycles; x7 = 0xFFFFF000, x5 = x6 = 0.
- Branches:
  - beq x6,x0,+372 at PC 0x18 (x6=0) -> next pcW 0x18C.
  - bne x7,x0 with x7 = 0xFFFFF000 -> taken.
  - bne x6,x0 -> not taken, next pcW = PC+4.
- Signed vs unsigned compare with x7 = 0xFFFFF000, x6 = 0:
  - blt x7,x6 taken; bge x7,x6 not taken.
  - bltu x7,x6 not taken; bgeu x7,x6 taken.
- Jumps:
  - 32'h02C00067 (jalr x0,44(x0)) -> next pcW 0x2C, no register write.
  - jalr x1,44(x0) at PC 0x100 -> x1 = 0x104.
  - jal x1,+8 at 0x40 -> pcW 0x48, x1 = 0x44.
- Loads/stores:
  - Setup: lui x5,0xF1F2F; addi x5,x5,0x3F4 -> x5 = 0xF1F2F3F4.
  - sw x5,4(x0) -> word 1 = 0xF1F2F3F4.
  - lb 7(x0) -> 0xFFFFFFF1; lbu 4(x0) -> 0x000000F4; lh 6(x0) -> 0xFFFFF1F2; lhu 4(x0) -> 0x0000F3F4.
  - sb x5,0(x0) then lw 0(x0) -> low byte 0xF4, other bytes unchanged.
- x0/reset mid-run: addi x0,x0,5 -> x0 still reads 0; asserting rstn=0 mid-program -> pcW immediately 0 and all registers 0, execution restarts at 0 after release.

Source files
------------

// File: rtl/xgriscv_sc.sv
// Single-cycle RV32I core with private instruction and data memories.
// Every instruction is fetched, executed and retired in one clock cycle;
// pcW exposes the PC of the instruction executing in the current cycle.

// Instruction memory: word array with combinational read, loaded externally.
module xgriscv_imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] idx_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] RAM [0:WORDS-1];

  assign rdata_o = RAM[idx_i];
endmodule

// Data memory: combinational read, byte-lane gated synchronous write.
module xgriscv_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] RAM [0:WORDS-1];

  assign rdata_o = RAM[idx_i];

  // Write only the enabled byte lanes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) RAM[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end
endmodule

module xgriscv_sc #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] pcW
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [0:31];
  logic [31:0] inst, dm_rdata, dm_wdata, mem_addr, wb_d, rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, alu_b, alu_y, pc_plus4;
  logic [31:0] ld_byte, ld_half;
  logic [3:0]  dm_be;
  logic        rd_we, br_taken, alu_legal;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  assign pcW = pc_q;

  xgriscv_imem #(.WORDS(IMEM_WORDS)) U_imem (
    .idx_i   (pc_q[IAW+1:2]),
    .rdata_o (inst)
  );

  xgriscv_dmem #(.WORDS(DMEM_WORDS)) U_dmem (
    .clk     (clk),
    .idx_i   (mem_addr[DAW+1:2]),
    .be_i    (dm_be),
    .wdata_i (dm_wdata),
    .rdata_o (dm_rdata)
  );

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  // Stores address through imm_s, everything else through imm_i.
  assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign ld_byte  = dm_rdata >> {mem_addr[1:0], 3'b000};
  assign ld_half  = mem_addr[1] ? {16'd0, dm_rdata[31:16]} : {16'd0, dm_rdata[15:0]};

  // Shared ALU for register-register and register-immediate forms.
  always_comb begin
    alu_b     = (opcode == OP_REG) ? rs2_val : imm_i;
    alu_y     = 32'd0;
    alu_legal = 1'b1;
    unique case (funct3)
      3'b000: alu_y = (opcode == OP_REG && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001: alu_y = rs1_val << alu_b[4:0];
      3'b010: alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_y = {31'd0, rs1_val < alu_b};
      3'b100: alu_y = rs1_val ^ alu_b;
      3'b101: alu_y = funct7[5] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'b110: alu_y = rs1_val | alu_b;
      default: alu_y = rs1_val & alu_b;
    endcase
    if (opcode == OP_REG) begin
      alu_legal = (funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
    end else if (funct3 == 3'b001) begin
      alu_legal = (funct7 == 7'h00);
    end else if (funct3 == 3'b101) begin
      alu_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
    end
  end

  // Branch condition; reserved funct3 codes never branch.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Decode/execute: next PC, write-back value and store lanes; unknown encodings act as nop.
  always_comb begin
    pc_d     = pc_plus4;
    wb_d     = 32'd0;
    rd_we    = 1'b0;
    dm_be    = 4'b0000;
    dm_wdata = rs2_val;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; wb_d = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; wb_d = pc_q + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; wb_d = pc_plus4; pc_d = pc_q + imm_j; end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we = 1'b1;
          wb_d  = pc_plus4;
          pc_d  = (rs1_val + imm_i) & 32'hFFFF_FFFE;
        end
      end
      OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OP_LOAD: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  wb_d = {{24{ld_byte[7]}}, ld_byte[7:0]};
          3'b001:  wb_d = {{16{ld_half[15]}}, ld_half[15:0]};
          3'b010:  wb_d = dm_rdata;
          3'b100:  wb_d = {24'd0, ld_byte[7:0]};
          3'b101:  wb_d = ld_half;
          default: rd_we = 1'b0;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'b000: begin dm_be = 4'b0001 << mem_addr[1:0]; dm_wdata = {4{rs2_val[7:0]}}; end
          3'b001: begin dm_be = mem_addr[1] ? 4'b1100 : 4'b0011; dm_wdata = {2{rs2_val[15:0]}}; end
          3'b010: dm_be = 4'b1111;
          default: dm_be = 4'b0000;
        endcase
      end
      OP_IMM, OP_REG: begin rd_we = alu_legal; wb_d = alu_y; end
      default: ;
    endcase
  end

  // Architectural state: PC and register file, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (rd_we && rd != 5'd0) rf_q[rd] <= wb_d;
    end
  end
endmodule

// File: tb/tb_xgriscv_sc.sv
// Bench for xgriscv_sc: an instruction-level reference model runs alongside
// the core and is compared every cycle; literal expectations pin key results.
module tb_xgriscv_sc;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pcW;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog [0:255];
  logic [31:0] m_rf [0:31];
  logic [31:0] m_mem [0:255];
  logic [31:0] m_pc;

  xgriscv_sc dut (.clk(clk), .rstn(rstn), .pcW(pcW));

  always #5 clk = ~clk;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JALR = 7'b1100111;
  localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011;

  function automatic logic [31:0] e_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                      logic [4:0] rd, logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] e_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] e_j(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0000_0013;
  endtask

  task automatic put(logic [31:0] addr, logic [31:0] ins);
    prog[addr[9:2]] = ins;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.U_imem.RAM[i] = prog[i];
  endtask

  task automatic m_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  // Reference: execute one instruction at ISA level on the model state.
  task automatic m_step();
    logic [31:0] ins, a, b, ii, si, bi, ji, npc, v, addr, w;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr, tk, alt;
    ins = prog[m_pc[9:2]];
    rd = ins[11:7]; f3 = ins[14:12]; alt = ins[30];
    a  = m_rf[ins[19:15]];
    b  = m_rf[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 4; v = 32'd0; wr = 1'b0; tk = 1'b0;
    case (ins[6:0])
      7'b0110111: begin wr = 1; v = {ins[31:12], 12'd0}; end
      7'b0010111: begin wr = 1; v = m_pc + {ins[31:12], 12'd0}; end
      7'b1101111: begin wr = 1; v = m_pc + 4; npc = m_pc + ji; end
      7'b1100111: begin wr = 1; v = m_pc + 4; npc = (a + ii) & ~32'd1; end
      7'b1100011: begin
        case (f3)
          0: tk = (a == b);
          1: tk = (a != b);
          4: tk = $signed(a) < $signed(b);
          5: tk = $signed(a) >= $signed(b);
          6: tk = a < b;
          7: tk = a >= b;
          default: tk = 0;
        endcase
        if (tk) npc = m_pc + bi;
      end
      7'b0000011: begin
        addr = a + ii; w = m_mem[addr[9:2]]; wr = 1;
        case (f3)
          0: begin v = w >> (8 * addr[1:0]); v = {{24{v[7]}}, v[7:0]}; end
          1: begin v = w >> (16 * addr[1]); v = {{16{v[15]}}, v[15:0]}; end
          2: v = w;
          4: begin v = w >> (8 * addr[1:0]); v = v & 32'hFF; end
          5: begin v = w >> (16 * addr[1]); v = v & 32'hFFFF; end
          default: wr = 0;
        endcase
      end
      7'b0100011: begin
        addr = a + si;
        case (f3)
          0: m_mem[addr[9:2]][8*addr[1:0] +: 8] = b[7:0];
          1: m_mem[addr[9:2]][16*addr[1] +: 16] = b[15:0];
          2: m_mem[addr[9:2]] = b;
          default: ;
        endcase
      end
      7'b0010011, 7'b0110011: begin
        if (ins[6:0] == 7'b0010011) b = ii;
        wr = 1;
        case (f3)
          0: v = (ins[5] && alt) ? a - b : a + b;
          1: v = a << b[4:0];
          2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3: v = (a < b) ? 32'd1 : 32'd0;
          4: v = a ^ b;
          5: v = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          6: v = a | b;
          default: v = a & b;
        endcase
      end
      default: ;
    endcase
    if (wr && rd != 0) m_rf[rd] = v;
    m_pc = npc;
  endtask

  task automatic check_regs_zero(string name);
    int bad = -1;
    for (int r = 0; r < 32; r++) if (bad < 0 && dut.rf_q[r] !== 32'd0) bad = r;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL %s: x%0d got %h expected 00000000", name, bad, dut.rf_q[bad]);
    end
  endtask

  // One compare point per cycle: DUT state against model, then advance the model.
  task automatic check_cycle();
    int bad = -1;
    chk("pcW_vs_model", pcW, m_pc);
    for (int r = 0; r < 32; r++) if (bad < 0 && dut.rf_q[r] !== m_rf[r]) bad = r;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL regfile_vs_model @pc %h: x%0d got %h expected %h", m_pc, bad, dut.rf_q[bad], m_rf[bad]);
    end
    $display("cycle pc=%h inst=%h", pcW, prog[m_pc[9:2]]);
    m_step();
  endtask

  task automatic restart();
    @(negedge clk);
    rstn = 1'b0;
    load_prog();
    m_reset();
    @(negedge clk);
    chk("reset_pcW", pcW, 32'd0);
    check_regs_zero("reset_regs");
    rstn = 1'b1;
  endtask

  logic [31:0] exp_pc [17] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h014, 32'h018,
                               32'h18C, 32'h194, 32'h198, 32'h19C, 32'h1A4, 32'h02C,
                               32'h030, 32'h040, 32'h048, 32'h100, 32'h02C};

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;

    // Fetch, branches and jumps.
    clear_prog();
    put(32'h000, e_i(0, 0, 0, 5, OPIMM));
    put(32'h004, e_i(0, 0, 0, 6, OPIMM));
    put(32'h008, e_u(20'hFFFFF, 7, LUI));
    put(32'h00C, e_b(8, 0, 7, 1));
    put(32'h010, e_i(1, 0, 0, 8, OPIMM));
    put(32'h014, e_b(8, 0, 6, 1));
    put(32'h018, e_b(372, 0, 6, 0));
    put(32'h18C, e_b(8, 6, 7, 4));
    put(32'h190, e_i(2, 0, 0, 8, OPIMM));
    put(32'h194, e_b(8, 6, 7, 5));
    put(32'h198, e_b(8, 6, 7, 6));
    put(32'h19C, e_b(8, 6, 7, 7));
    put(32'h1A0, e_i(7, 0, 0, 8, OPIMM));
    put(32'h1A4, 32'h02C00067);
    put(32'h02C, e_i(3, 0, 0, 9, OPIMM));
    put(32'h030, e_j(16, 0));
    put(32'h040, e_j(8, 1));
    put(32'h044, e_i(4, 0, 0, 8, OPIMM));
    put(32'h048, e_j(32'hB8, 0));
    put(32'h100, e_i(44, 0, 0, 1, JALR));
    restart();
    for (int i = 0; i < 17; i++) begin
      chk("pc_sequence", pcW, exp_pc[i]);
      if (i == 3) begin
        chk("lui_x7", dut.rf_q[7], 32'hFFFFF000);
        chk("addi_x5", dut.rf_q[5], 32'd0);
      end
      if (i == 14) chk("jal_link_x1", dut.rf_q[1], 32'h44);
      if (i == 11) chk("jalr_x0_no_link", dut.rf_q[1], 32'd0);
      check_cycle();
      @(negedge clk);
    end
    chk("jalr_link_x1", dut.rf_q[1], 32'h104);
    chk("skipped_x8", dut.rf_q[8], 32'd0);
    chk("target_x9", dut.rf_q[9], 32'd3);

    // Loads, stores, ALU, x0 and an unsupported encoding.
    clear_prog();
    put(32'h00, e_u(20'hF1F2F, 5, LUI));
    put(32'h04, e_i(32'h3F4, 5, 0, 5, OPIMM));
    put(32'h08, e_s(4, 5, 0, 2));
    put(32'h0C, e_i(7, 0, 0, 10, LOAD));
    put(32'h10, e_i(4, 0, 4, 11, LOAD));
    put(32'h14, e_i(6, 0, 1, 12, LOAD));
    put(32'h18, e_i(4, 0, 5, 13, LOAD));
    put(32'h1C, e_u(20'h12345, 14, LUI));
    put(32'h20, e_i(32'h678, 14, 0, 14, OPIMM));
    put(32'h24, e_s(0, 14, 0, 2));
    put(32'h28, e_s(0, 5, 0, 0));
    put(32'h2C, e_i(0, 0, 2, 15, LOAD));
    put(32'h30, e_i(5, 0, 0, 0, OPIMM));
    put(32'h34, e_r(0, 5, 0, 0, 16));
    put(32'h38, e_s(2, 5, 0, 1));
    put(32'h3C, e_i(0, 0, 2, 17, LOAD));
    put(32'h40, e_r(7'h20, 5, 0, 0, 18));
    put(32'h44, e_i(32'h404, 5, 5, 19, OPIMM));
    put(32'h48, e_i(4, 5, 5, 20, OPIMM));
    put(32'h4C, e_r(0, 14, 5, 2, 21));
    put(32'h50, e_r(0, 14, 5, 3, 22));
    put(32'h54, e_i(36, 0, 0, 28, OPIMM));
    put(32'h58, e_r(7'h20, 28, 5, 5, 27));
    put(32'h5C, 32'h00000073);
    put(32'h60, e_u(20'h00001, 25, AUIPC));
    put(32'h64, e_i(5, 0, 2, 26, LOAD));
    put(32'h68, e_i(-1, 5, 3, 29, OPIMM));
    put(32'h6C, e_i(-1, 14, 4, 30, OPIMM));
    put(32'h70, e_r(0, 28, 14, 1, 31));
    put(32'h74, e_i(32'hFF, 5, 7, 24, OPIMM));
    put(32'h78, e_i(-2048, 0, 6, 23, OPIMM));
    put(32'h7C, e_r(0, 28, 5, 5, 9));
    put(32'h80, e_r(0, 14, 5, 7, 8));
    put(32'h84, e_r(0, 14, 5, 6, 7));
    put(32'h88, e_r(0, 14, 5, 4, 6));
    put(32'h8C, e_i(0, 5, 2, 4, OPIMM));
    put(32'h90, e_j(0, 0));
    restart();
    for (int i = 0; i < 40; i++) begin
      check_cycle();
      @(negedge clk);
    end
    chk("x5_setup", dut.rf_q[5], 32'hF1F2F3F4);
    chk("sw_word1", dut.U_dmem.RAM[1], 32'hF1F2F3F4);
    chk("lb_7", dut.rf_q[10], 32'hFFFFFFF1);
    chk("lbu_4", dut.rf_q[11], 32'h000000F4);
    chk("lh_6", dut.rf_q[12], 32'hFFFFF1F2);
    chk("lhu_4", dut.rf_q[13], 32'h0000F3F4);
    chk("sb_then_lw", dut.rf_q[15], 32'h123456F4);
    chk("x0_write_dropped", dut.rf_q[0], 32'd0);
    chk("add_x0_src", dut.rf_q[16], 32'hF1F2F3F4);
    chk("sh_then_lw", dut.rf_q[17], 32'hF3F456F4);
    chk("sub", dut.rf_q[18], 32'h0E0D0C0C);
    chk("srai", dut.rf_q[19], 32'hFF1F2F3F);
    chk("srli", dut.rf_q[20], 32'h0F1F2F3F);
    chk("slt", dut.rf_q[21], 32'd1);
    chk("sltu", dut.rf_q[22], 32'd0);
    chk("sra_shamt_low5", dut.rf_q[27], 32'hFF1F2F3F);
    chk("auipc", dut.rf_q[25], 32'h00001060);
    chk("lw_misaligned", dut.rf_q[26], 32'hF1F2F3F4);
    chk("xori", dut.rf_q[30], 32'hEDCBA987);
    chk("sll", dut.rf_q[31], 32'h23456780);
    chk("and", dut.rf_q[8], 32'h10305270);
    chk("or", dut.rf_q[7], 32'hF3F6F7FC);
    chk("xor", dut.rf_q[6], 32'hE3C6A58C);
    chk("ori_neg", dut.rf_q[23], 32'hFFFFF800);
    chk("self_loop_pc", pcW, 32'h90);

    // Asynchronous reset mid-run, then restart from 0.
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_pcW", pcW, 32'd0);
    check_regs_zero("async_reset_regs");
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_cycle();
      @(negedge clk);
    end
    chk("restart_x15", dut.rf_q[15], 32'h123456F4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
